wino_pad_bridge: RTL

Parametrised pad-side bridge between the chip's narrow pad buses and a Winograd tile core. It deserialises pad input beats into wide core words and tags each word with a channel index and frame-last flag. It serialises core result words back onto the pad output bus through a small output FIFO. It sits between the pad ring and the core, replacing the direct D/Z pad-to-core wiring of the previous generation.

---
 rtl/wino_pad_bridge.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/wino_pad_bridge.sv
// Pad-side bridge for the Winograd tile core: deserialises pad beats into tagged
// core input words and serialises core result words back onto the pad bus via a FIFO.
module wino_pad_bridge #(
   parameter int PAD_W     = 10,
   parameter int IN_BEATS  = 2,
   parameter int OUT_BEATS = 2,
   parameter int NCH       = 4,
   parameter int OUT_DEPTH = 4,
   localparam int CI_W     = PAD_W * IN_BEATS,
   localparam int CO_W     = PAD_W * OUT_BEATS,
   localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [PAD_W-1:0] i_pad_d,
   input  logic             i_pad_d_vld,
   input  logic             i_pad_sync,
   output logic [CI_W-1:0]  o_core_d,
   output logic [CH_W-1:0]  o_core_d_ch,
   output logic             o_core_d_last,
   output logic             o_core_d_valid,
   input  logic             i_core_d_ready,
   input  logic [CO_W-1:0]  i_core_z,
   input  logic             i_core_z_valid,
   output logic             o_core_z_ready,
   output logic [PAD_W-1:0] o_pad_z,
   output logic             o_pad_z_vld,
   output logic             o_ovf
);

   localparam int BEAT_W = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
   localparam int OB_W   = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
   localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CNT_W  = $clog2(OUT_DEPTH + 1);

   typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

   logic [CI_W-1:0]   r_asm;
   logic [BEAT_W-1:0] r_beat_cnt;
   logic [CH_W-1:0]   r_ch_cnt;
   logic [CI_W-1:0]   r_hold_d;
   logic [CH_W-1:0]   r_hold_ch;
   logic              r_hold_vld;
   logic              r_ovf;

   logic [BEAT_W-1:0] w_beat_idx;
   logic [CH_W-1:0]   w_ch_idx;
   logic [CI_W-1:0]   w_word;
   logic              w_word_done;
   logic              w_accept;

   // A resync restarts the frame; a beat arriving with it becomes beat 0 of channel 0.
   assign w_beat_idx  = i_pad_sync ? '0 : r_beat_cnt;
   assign w_ch_idx    = i_pad_sync ? '0 : r_ch_cnt;
   assign w_word_done = i_pad_d_vld && (w_beat_idx == BEAT_W'(IN_BEATS - 1));
   assign w_accept    = r_hold_vld & i_core_d_ready;

   always_comb begin
      w_word = r_asm;
      for (int b = 0; b < IN_BEATS; b++) begin
         if (w_beat_idx == BEAT_W'(b)) begin
            w_word[b*PAD_W +: PAD_W] = i_pad_d;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_asm      <= '0;
         r_beat_cnt <= '0;
         r_ch_cnt   <= '0;
         r_hold_d   <= '0;
         r_hold_ch  <= '0;
         r_hold_vld <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_hold_vld <= 1'b0;
         end
         if (i_pad_d_vld) begin
            r_asm <= w_word;
            if (w_word_done) begin
               r_beat_cnt <= '0;
               r_ch_cnt   <= (w_ch_idx == CH_W'(NCH - 1)) ? '0 : w_ch_idx + CH_W'(1);
               if (r_hold_vld && !w_accept) begin
                  r_ovf <= 1'b1;
               end else begin
                  r_hold_d   <= w_word;
                  r_hold_ch  <= w_ch_idx;
                  r_hold_vld <= 1'b1;
               end
            end else begin
               r_beat_cnt <= w_beat_idx + BEAT_W'(1);
               r_ch_cnt   <= w_ch_idx;
            end
         end else if (i_pad_sync) begin
            r_beat_cnt <= '0;
            r_ch_cnt   <= '0;
         end
      end
   end

   assign o_core_d       = r_hold_d;
   assign o_core_d_ch    = r_hold_ch;
   assign o_core_d_valid = r_hold_vld;
   assign o_core_d_last  = r_hold_vld && (r_hold_ch == CH_W'(NCH - 1));
   assign o_ovf          = r_ovf;

   logic [CO_W-1:0]  r_mem [OUT_DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   assign w_full         = (r_count == CNT_W'(OUT_DEPTH));
   assign w_empty        = (r_count == '0);
   assign o_core_z_ready = i_rst & ~w_full;
   assign w_push         = i_core_z_valid & o_core_z_ready;

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_core_z;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   ser_state_t       r_state;
   ser_state_t       w_state_nxt;
   logic [CO_W-1:0]  r_shift;
   logic [OB_W-1:0]  r_ob_cnt;
   logic [PAD_W-1:0] r_pad_z;
   logic             r_pad_z_vld;
   logic [PAD_W-1:0] w_beat_out;
   logic             w_ob_last;

   assign w_ob_last = (r_ob_cnt == OB_W'(OUT_BEATS - 1));

   always_comb begin
      w_beat_out = '0;
      for (int b = 0; b < OUT_BEATS; b++) begin
         if (r_ob_cnt == OB_W'(b)) begin
            w_beat_out = r_shift[b*PAD_W +: PAD_W];
         end
      end
   end

   // Popping on the last beat keeps pad_z_vld continuous across back-to-back words.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_ob_last) begin
               if (!w_empty) begin
                  w_pop = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_ob_cnt    <= '0;
         r_pad_z     <= '0;
         r_pad_z_vld <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop) begin
            r_shift  <= r_mem[r_rptr];
            r_ob_cnt <= '0;
         end else if (r_state == S_SHIFT && !w_ob_last) begin
            r_ob_cnt <= r_ob_cnt + OB_W'(1);
         end
         r_pad_z     <= (r_state == S_SHIFT) ? w_beat_out : '0;
         r_pad_z_vld <= (r_state == S_SHIFT);
      end
   end

   assign o_pad_z     = r_pad_z;
   assign o_pad_z_vld = r_pad_z_vld;

endmodule
